cordic_rot_arbiter: RTL and testbench
=====================================

Name: cordic_rot_arbiter

Overview:
Shares one iterative cordic_rotating unit among NREQ independent requesters, for example the Givens-rotation and angle (sin/cos) generation paths of the matrix FSM. It grants requesters in round-robin order and captures the winner's operands. It drives the CORDIC start pulse, tracks which requester owns the op in flight, and routes the result back with a per-requester valid pulse. A watchdog returns the arbiter to IDLE if the CORDIC never answers.

Parameters:
DATA_WIDTH, 32, width of x, y, theta and results
NREQ, 3, number of requesters (2..8)
TIMEOUT, 64, max cycles in WAIT before abort (>= CORDIC latency + 2)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
req  in  NREQ  request level per requester; operands held stable while high and not yet granted
req_x  in  NREQ*DATA_WIDTH  packed x operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_y  in  NREQ*DATA_WIDTH  packed y operands
req_theta  in  NREQ*DATA_WIDTH  packed angle operands
gnt  out  NREQ  one-cycle one-hot pulse: operands of requester i captured
rsp_valid  out  NREQ  one-cycle one-hot pulse: rsp_x/rsp_y belong to requester i
rsp_x  out  DATA_WIDTH  result x, shared, held until next response
rsp_y  out  DATA_WIDTH  result y, shared, held until next response
cor_start  out  1  start pulse to cordic_rotating
cor_x  out  DATA_WIDTH  registered x_in to CORDIC
cor_y  out  DATA_WIDTH  registered y_in to CORDIC
cor_theta  out  DATA_WIDTH  registered theta_in to CORDIC
cor_valid  in  1  CORDIC valid pulse
cor_x_out  in  DATA_WIDTH  CORDIC x result
cor_y_out  in  DATA_WIDTH  CORDIC y result
busy  out  1  high whenever state is WAIT
timeout_err  out  1  sticky; set on watchdog abort, cleared only by RST

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous, active-high, on RST.
- Registered outputs: all outputs are registered.
- Reset values: state=IDLE, gnt=0, rsp_valid=0, rsp_x=0, rsp_y=0, cor_start=0, cor_x/y/theta=0, busy=0, timeout_err=0, owner=0, ptr=NREQ-1 (requester 0 has first priority), wdog=0.
- RST mid-operation: an RST asserted while in WAIT drops the op. No rsp_valid is issued. A later cor_valid is ignored because the arbiter is in IDLE.
- States: IDLE and WAIT.
- IDLE, no req bit set: stay in IDLE.
- IDLE, req!=0: search order is ptr+1, ptr+2, ... modulo NREQ; the first set bit wins (index w). At the clock edge:
  - cor_x/y/theta <= operands of w
  - gnt[w] <= 1 and cor_start <= 1, both for exactly one cycle
  - owner <= w, ptr <= w, wdog <= 0, state <= WAIT
- Grant latency: req sampled high in IDLE at cycle t gives gnt and cor_start high in cycle t+1.
- WAIT: req is not sampled. A requester that sees gnt may keep req high to queue a new op; that op competes at the next IDLE cycle. wdog increments each cycle.
- WAIT, cor_valid=1: at the edge, rsp_x <= cor_x_out, rsp_y <= cor_y_out, rsp_valid[owner] <= 1 for one cycle, state <= IDLE.
- WAIT, wdog == TIMEOUT-1 and cor_valid=0: abort. rsp_x=rsp_y=0, rsp_valid[owner] pulses for one cycle, timeout_err <= 1, state <= IDLE.
- cor_valid in the same cycle as the timeout condition: treated as a normal completion, no error.
- cor_valid while in IDLE (late or spurious): ignored; rsp_* unchanged.
- Back-to-back ops: rsp_valid for op n and the IDLE sampling of the next req fall in the same cycle. The next gnt/cor_start follows one cycle later, so the minimum gap from cor_valid to the next cor_start is 2 cycles.
- Output invariants: gnt and rsp_valid are never multi-hot. cor_start pulses only coincident with a gnt bit.
- Data handling: operands and results pass through unmodified; there is no arithmetic in this block. The width of ptr, owner and wdog is sized by $clog2.

Test Plan:
- Single request. Setup: CORDIC stub with latency 20 returning (x+1, y+2); req=3'b010, x=256, y=0, theta=100 at cycle 5. Required: gnt=3'b010 and cor_start at cycle 6, cor_x=256. Stub valid at cycle 26, then rsp_valid=3'b010 at cycle 27 with rsp_x=257, rsp_y=2. busy high in cycles 6..26.
- Round robin. Stimulus: req=3'b111 held continuously from reset. Required: grant order 0,1,2,0,…; each rsp_valid bit matches the preceding gnt bit; consecutive cor_start pulses are 22 cycles apart with latency 20.
- Fairness under contention. Stimulus: requester 0 re-requests immediately after each gnt while requester 2 is pending. Required: requester 2 is granted no later than the second grant after it raises req.
- Timeout. Setup: stub never returns valid, TIMEOUT=64. Required: rsp_valid[owner] pulses 64 cycles after gnt with rsp_x=rsp_y=0; timeout_err=1 and stays 1 through further traffic until RST.
- Timeout/valid coincidence and late valid. First stimulus: cor_valid lands exactly on wdog==TIMEOUT-1. Required: normal result, timeout_err stays 0. Second stimulus: cor_valid pulsed while in IDLE. Required: no rsp_valid, rsp_x/rsp_y unchanged.
- Reset mid-operation. Stimulus: RST for one cycle 5 cycles after gnt. Required: all outputs at reset values on the next cycle; the subsequent stub valid produces no rsp_valid; the next req=3'b100 is granted to requester 0 only if req[0] is set, otherwise requester 2.

Source files
------------

// File: rtl/cordic_rot_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC rotator among NREQ requesters.
// Captures the winner's operands, issues the start pulse and routes the result back.
module cordic_rot_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int NREQ       = 3,
   parameter int TIMEOUT    = 64
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [NREQ-1:0]            req,
   input  logic [NREQ*DATA_WIDTH-1:0] req_x,
   input  logic [NREQ*DATA_WIDTH-1:0] req_y,
   input  logic [NREQ*DATA_WIDTH-1:0] req_theta,
   output logic [NREQ-1:0]            gnt,
   output logic [NREQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_x,
   output logic [DATA_WIDTH-1:0]      rsp_y,
   output logic                       cor_start,
   output logic [DATA_WIDTH-1:0]      cor_x,
   output logic [DATA_WIDTH-1:0]      cor_y,
   output logic [DATA_WIDTH-1:0]      cor_theta,
   input  logic                       cor_valid,
   input  logic [DATA_WIDTH-1:0]      cor_x_out,
   input  logic [DATA_WIDTH-1:0]      cor_y_out,
   output logic                       busy,
   output logic                       timeout_err
);

   localparam int IW = $clog2(NREQ);
   localparam int WW = $clog2(TIMEOUT);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          ptr_q, ptr_d;
   logic [IW-1:0]          owner_q, owner_d;
   logic [WW-1:0]          wdog_q, wdog_d;
   logic [NREQ-1:0]        gnt_q, gnt_d;
   logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_x_q, rsp_x_d;
   logic [DATA_WIDTH-1:0]  rsp_y_q, rsp_y_d;
   logic                   cor_start_q, cor_start_d;
   logic [DATA_WIDTH-1:0]  cor_x_q, cor_x_d;
   logic [DATA_WIDTH-1:0]  cor_y_q, cor_y_d;
   logic [DATA_WIDTH-1:0]  cor_theta_q, cor_theta_d;
   logic                   busy_q, busy_d;
   logic                   timeout_err_q, timeout_err_d;

   logic                   win_found_s;
   logic [IW-1:0]          win_idx_s;
   logic [IW-1:0]          cand_s;
   logic [DATA_WIDTH-1:0]  op_x_s, op_y_s, op_theta_s;
   logic                   wdog_expired_s;

   // Round-robin search starting one past the last winner.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      cand_s      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand_s = IW'((int'(ptr_q) + k) % NREQ);
         if (!win_found_s && req[cand_s]) begin
            win_found_s = 1'b1;
            win_idx_s   = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Operand mux for the winning requester.
   always_comb begin
      op_x_s     = '0;
      op_y_s     = '0;
      op_theta_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx_s == IW'(i)) begin
            op_x_s     = req_x[i*DATA_WIDTH +: DATA_WIDTH];
            op_y_s     = req_y[i*DATA_WIDTH +: DATA_WIDTH];
            op_theta_s = req_theta[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            op_x_s     = op_x_s;
         end
      end
   end

   assign wdog_expired_s = (wdog_q == WW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) state_d = ST_WAIT;
            else             state_d = ST_IDLE;
         end
         ST_WAIT: begin
            if (cor_valid || wdog_expired_s) state_d = ST_IDLE;
            else                             state_d = ST_WAIT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and datapath next values; a CORDIC answer on the expiry cycle wins over the abort.
   always_comb begin
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      wdog_d        = wdog_q;
      gnt_d         = '0;
      rsp_valid_d   = '0;
      rsp_x_d       = rsp_x_q;
      rsp_y_d       = rsp_y_q;
      cor_start_d   = 1'b0;
      cor_x_d       = cor_x_q;
      cor_y_d       = cor_y_q;
      cor_theta_d   = cor_theta_q;
      timeout_err_d = timeout_err_q;
      busy_d        = (state_d == ST_WAIT);
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) begin
               gnt_d[win_idx_s] = 1'b1;
               cor_start_d      = 1'b1;
               cor_x_d          = op_x_s;
               cor_y_d          = op_y_s;
               cor_theta_d      = op_theta_s;
               owner_d          = win_idx_s;
               ptr_d            = win_idx_s;
               wdog_d           = '0;
            end else begin
               wdog_d           = wdog_q;
            end
         end
         ST_WAIT: begin
            wdog_d = wdog_q + WW'(1);
            if (cor_valid) begin
               rsp_x_d              = cor_x_out;
               rsp_y_d              = cor_y_out;
               rsp_valid_d[owner_q] = 1'b1;
            end else if (wdog_expired_s) begin
               rsp_x_d              = '0;
               rsp_y_d              = '0;
               rsp_valid_d[owner_q] = 1'b1;
               timeout_err_d        = 1'b1;
            end else begin
               rsp_valid_d          = '0;
            end
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q         <= IW'(NREQ - 1);
         owner_q       <= '0;
         wdog_q        <= '0;
         gnt_q         <= '0;
         rsp_valid_q   <= '0;
         rsp_x_q       <= '0;
         rsp_y_q       <= '0;
         cor_start_q   <= 1'b0;
         cor_x_q       <= '0;
         cor_y_q       <= '0;
         cor_theta_q   <= '0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         wdog_q        <= wdog_d;
         gnt_q         <= gnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_x_q       <= rsp_x_d;
         rsp_y_q       <= rsp_y_d;
         cor_start_q   <= cor_start_d;
         cor_x_q       <= cor_x_d;
         cor_y_q       <= cor_y_d;
         cor_theta_q   <= cor_theta_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign gnt         = gnt_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_x       = rsp_x_q;
   assign rsp_y       = rsp_y_q;
   assign cor_start   = cor_start_q;
   assign cor_x       = cor_x_q;
   assign cor_y       = cor_y_q;
   assign cor_theta   = cor_theta_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cordic_rot_arbiter.sv
// Directed bench for cordic_rot_arbiter with a latency-programmable CORDIC stub
// that answers (x+1, y+2).
module tb_cordic_rot_arbiter;

   logic          CLK = 1'b0;
   logic          RST;
   logic [2:0]    req;
   logic [95:0]   req_x, req_y, req_theta;
   logic [2:0]    gnt, rsp_valid;
   logic [31:0]   rsp_x, rsp_y;
   logic          cor_start;
   logic [31:0]   cor_x, cor_y, cor_theta;
   logic          cor_valid;
   logic [31:0]   cor_x_out, cor_y_out;
   logic          busy, timeout_err;

   logic          stub_valid = 1'b0;
   logic          man_valid;
   logic          stub_en;
   int            stub_lat;
   int            stub_cnt = 0;
   int            cyc = 0;
   int            n_assert = 0;
   int            n_fail = 0;

   cordic_rot_arbiter #(.DATA_WIDTH(32), .NREQ(3), .TIMEOUT(64)) dut (
      .CLK(CLK), .RST(RST), .req(req), .req_x(req_x), .req_y(req_y),
      .req_theta(req_theta), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_x(rsp_x),
      .rsp_y(rsp_y), .cor_start(cor_start), .cor_x(cor_x), .cor_y(cor_y),
      .cor_theta(cor_theta), .cor_valid(cor_valid), .cor_x_out(cor_x_out),
      .cor_y_out(cor_y_out), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // CORDIC stub: valid lands stub_lat cycles after the cor_start cycle.
   always @(posedge CLK) begin
      if (cor_start && stub_en) begin
         stub_cnt   <= stub_lat - 1;
         stub_valid <= 1'b0;
      end else if (stub_cnt > 1) begin
         stub_cnt   <= stub_cnt - 1;
         stub_valid <= 1'b0;
      end else if (stub_cnt == 1) begin
         stub_cnt   <= 0;
         stub_valid <= 1'b1;
         cor_x_out  <= cor_x + 32'd1;
         cor_y_out  <= cor_y + 32'd2;
      end else begin
         stub_valid <= 1'b0;
      end
   end

   assign cor_valid = stub_valid | man_valid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_gnt(input int limit, output logic [2:0] g, output int at);
      g  = 3'b000;
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (gnt != 3'b000) begin
            g  = gnt;
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL gnt_wait: observed no grant, expected one within %0d cycles", limit);
      end
   endtask

   task automatic wait_rsp(input int limit, output logic [2:0] r, output int at);
      r  = 3'b000;
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge CLK);
         if (rsp_valid != 3'b000) begin
            r  = rsp_valid;
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_assert++;
         n_fail++;
         $display("FAIL rsp_wait: observed no response, expected one within %0d cycles", limit);
      end
   endtask

   initial begin
      logic [2:0] g, r;
      int         g_at, r_at, prev_at, seen;
      int         exp_idx [4] = '{0, 1, 2, 0};

      RST = 1'b1; req = 3'b000; req_x = '0; req_y = '0; req_theta = '0;
      man_valid = 1'b0; stub_en = 1'b1; stub_lat = 20;
      step(3);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_x", rsp_x, 32'd0);
      check("rst_cor_start", 32'(cor_start), 32'd0);
      check("rst_cor_x", cor_x, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      RST = 1'b0;

      // Single request from requester 1.
      req_x = {32'd0, 32'd256, 32'd0}; req_y = '0; req_theta = {32'd0, 32'd100, 32'd0};
      req = 3'b010;
      step(1);
      check("t1_gnt", 32'(gnt), 32'h2);
      check("t1_cor_start", 32'(cor_start), 32'd1);
      check("t1_cor_x", cor_x, 32'd256);
      check("t1_cor_theta", cor_theta, 32'd100);
      check("t1_busy_first", 32'(busy), 32'd1);
      req = 3'b000;
      step(19);
      check("t1_no_rsp_yet", 32'(rsp_valid), 32'd0);
      check("t1_gnt_single", 32'(gnt), 32'd0);
      step(1);
      check("t1_busy_last", 32'(busy), 32'd1);
      step(1);
      check("t1_rsp_valid", 32'(rsp_valid), 32'h2);
      check("t1_rsp_x", rsp_x, 32'd257);
      check("t1_rsp_y", rsp_y, 32'd2);
      check("t1_busy_done", 32'(busy), 32'd0);
      step(1);
      check("t1_rsp_pulse", 32'(rsp_valid), 32'd0);
      check("t1_rsp_x_held", rsp_x, 32'd257);

      // Round robin with all three requesting continuously.
      RST = 1'b1; step(1); RST = 1'b0;
      req_x = {32'h300, 32'h200, 32'h100}; req_y = {32'd30, 32'd20, 32'd10};
      req = 3'b111;
      prev_at = 0;
      for (int n = 0; n < 4; n++) begin
         wait_gnt(40, g, g_at);
         check("rr_gnt", 32'(g), 32'(3'b001 << exp_idx[n]));
         check("rr_cor_x", cor_x, 32'h100 * 32'(exp_idx[n] + 1));
         if (n > 0) check("rr_gap", 32'(g_at - prev_at), 32'd22);
         prev_at = g_at;
         if (n == 3) req = 3'b000;
         wait_rsp(30, r, r_at);
         check("rr_rsp_owner", 32'(r), 32'(3'b001 << exp_idx[n]));
         check("rr_rsp_x", rsp_x, 32'h100 * 32'(exp_idx[n] + 1) + 32'd1);
      end

      // Fairness: requester 0 re-requests while requester 2 is pending.
      RST = 1'b1; step(1); RST = 1'b0;
      req_x = {32'h33, 32'h22, 32'h11};
      req = 3'b001;
      wait_gnt(10, g, g_at);
      check("fair_gnt0", 32'(g), 32'h1);
      req = 3'b101;
      wait_rsp(30, r, r_at);
      wait_gnt(10, g, g_at);
      check("fair_gnt2", 32'(g), 32'h4);
      req = 3'b001;
      wait_rsp(30, r, r_at);
      wait_gnt(10, g, g_at);
      check("fair_gnt0_again", 32'(g), 32'h1);
      req = 3'b000;
      wait_rsp(30, r, r_at);
      check("fair_rsp_x", rsp_x, 32'h12);

      // cor_valid coincides with the last watchdog cycle.
      stub_lat = 63;
      req_x = {32'd0, 32'd5, 32'd0}; req_y = {32'd0, 32'd6, 32'd0};
      req = 3'b010;
      wait_gnt(10, g, g_at);
      check("coin_gnt", 32'(g), 32'h2);
      req = 3'b000;
      wait_rsp(80, r, r_at);
      check("coin_delay", 32'(r_at - g_at), 32'd64);
      check("coin_rsp_valid", 32'(r), 32'h2);
      check("coin_rsp_x", rsp_x, 32'd6);
      check("coin_rsp_y", rsp_y, 32'd8);
      check("coin_no_err", 32'(timeout_err), 32'd0);

      // Spurious cor_valid while idle.
      step(2);
      man_valid = 1'b1;
      step(1);
      man_valid = 1'b0;
      check("late_no_rsp", 32'(rsp_valid), 32'd0);
      check("late_rsp_x", rsp_x, 32'd6);
      check("late_rsp_y", rsp_y, 32'd8);
      check("late_busy", 32'(busy), 32'd0);

      // Watchdog abort: stub stays silent.
      stub_en = 1'b0; stub_lat = 20;
      req_x = {32'd7, 32'd0, 32'h40};
      req = 3'b100;
      wait_gnt(10, g, g_at);
      check("to_gnt", 32'(g), 32'h4);
      req = 3'b000;
      wait_rsp(80, r, r_at);
      check("to_delay", 32'(r_at - g_at), 32'd64);
      check("to_rsp_valid", 32'(r), 32'h4);
      check("to_rsp_x", rsp_x, 32'd0);
      check("to_rsp_y", rsp_y, 32'd0);
      check("to_err", 32'(timeout_err), 32'd1);
      stub_en = 1'b1;
      req = 3'b001;
      wait_gnt(10, g, g_at);
      check("to_next_gnt", 32'(g), 32'h1);
      req = 3'b000;
      wait_rsp(30, r, r_at);
      check("to_next_rsp_x", rsp_x, 32'h41);
      check("to_err_sticky", 32'(timeout_err), 32'd1);

      // Reset while an operation is in flight.
      req_x = {32'h77, 32'd9, 32'd0};
      req = 3'b010;
      wait_gnt(10, g, g_at);
      check("mid_gnt", 32'(g), 32'h2);
      req = 3'b000;
      step(4);
      RST = 1'b1;
      step(1);
      RST = 1'b0;
      check("mid_gnt_rst", 32'(gnt), 32'd0);
      check("mid_rsp_x_rst", rsp_x, 32'd0);
      check("mid_rsp_y_rst", rsp_y, 32'd0);
      check("mid_cor_x_rst", cor_x, 32'd0);
      check("mid_busy_rst", 32'(busy), 32'd0);
      check("mid_err_rst", 32'(timeout_err), 32'd0);
      seen = 0;
      for (int i = 0; i < 25; i++) begin
         step(1);
         if (rsp_valid != 3'b000) seen++;
      end
      check("mid_no_rsp", 32'(seen), 32'd0);
      check("mid_rsp_x_held", rsp_x, 32'd0);
      req = 3'b100;
      wait_gnt(10, g, g_at);
      check("mid_next_gnt", 32'(g), 32'h4);
      req = 3'b000;
      wait_rsp(30, r, r_at);
      check("mid_next_rsp", 32'(r), 32'h4);
      check("mid_next_rsp_x", rsp_x, 32'h78);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
